top_level: RTL and testbench

//  Fixed-function engine with a private 256x8 data memory. Each req pulse runs the next of

---
 rtl/top_level_pkg.sv | 76 +++++++
 rtl/top_level_data_mem.sv | 21 ++
 rtl/top_level.sv | 246 ++++++++++++++++++++++++
 tb/tb_top_level.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/top_level_pkg.sv
// Shared types, memory map and Hamming(16,11)+overall-parity helpers for top_level.
package top_level_pkg;

  localparam int NWORDS = 15;
  localparam int NBYTES = 32;

  // Memory map of the private data memory
  localparam logic [7:0] P1_IN  = 8'd0;
  localparam logic [7:0] P1_OUT = 8'd30;
  localparam logic [7:0] P2_IN  = 8'd64;
  localparam logic [7:0] P2_OUT = 8'd94;
  localparam logic [7:0] STR    = 8'd128;
  localparam logic [7:0] PAT    = 8'd160;
  localparam logic [7:0] RES    = 8'd192;

  typedef enum logic [4:0] {
    IDLE,
    J1_RD_HI, J1_RD_LO, J1_WR_HI, J1_WR_LO,
    J2_RD_HI, J2_RD_LO, J2_WR_HI, J2_WR_LO,
    J3_LD_PAT, J3_SCAN, J3_WR192, J3_WR193, J3_WR194,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    JOB_ENC = 2'd1,
    JOB_DEC = 2'd2,
    JOB_PAT = 2'd3
  } job_t;

  // Round-robin successor: 1 -> 2 -> 3 -> 1
  function automatic job_t next_job(input job_t j);
    case (j)
      JOB_ENC: return JOB_DEC;
      JOB_DEC: return JOB_PAT;
      default: return JOB_ENC;
    endcase
  endfunction

  // Codeword layout [15:0] = d11 d10 d9 d8 d7 d6 d5 p8 d4 d3 d2 p4 d1 p2 p1 p16
  function automatic logic [15:0] ham_encode(input logic [10:0] d);
    logic [15:0] cw;
    cw        = '0;
    cw[3]     = d[0];
    cw[7:5]   = d[3:1];
    cw[15:9]  = d[10:4];
    cw[1]     = cw[3] ^ cw[5] ^ cw[7] ^ cw[9]  ^ cw[11] ^ cw[13] ^ cw[15];
    cw[2]     = cw[3] ^ cw[6] ^ cw[7] ^ cw[10] ^ cw[11] ^ cw[14] ^ cw[15];
    cw[4]     = cw[5] ^ cw[6] ^ cw[7] ^ cw[12] ^ cw[13] ^ cw[14] ^ cw[15];
    cw[8]     = ^cw[15:9];
    cw[0]     = ^cw[15:1];
    return cw;
  endfunction

  // XOR of the indices of all set bits 15:1; bit 0 (overall parity) never contributes
  function automatic logic [3:0] ham_syndrome(input logic [15:0] cw);
    logic [3:0] syn;
    syn[0] = ^(cw & 16'hAAAA);
    syn[1] = ^(cw & 16'hCCCC);
    syn[2] = ^(cw & 16'hF0F0);
    syn[3] = ^(cw & 16'hFF00);
    return syn;
  endfunction

  // Single-error correction followed by data extraction (d11..d1 -> [10:0])
  function automatic logic [10:0] ham_decode(input logic [15:0] cw);
    logic [3:0]  syn;
    logic [15:0] fix;
    syn = ham_syndrome(cw);
    fix = cw;
    if (syn != 4'd0) begin
      fix = cw ^ (16'd1 << syn);
    end
    return {fix[15:9], fix[7:5], fix[3]};
  endfunction

endpackage

// File: rtl/top_level_data_mem.sv
// 256x8 single-port data memory: combinational read, synchronous write, never cleared.
module data_mem (
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);

  logic [7:0] core [0:255];

  // Synchronous write port
  always_ff @(posedge clk) begin
    if (we) begin
      core[addr] <= wdata;
    end
  end

  assign rdata = core[addr];

endmodule

// File: rtl/top_level.sv
// Job engine: round-robin Hamming encode, Hamming decode and 5-bit pattern counting over
// a private data memory, one memory access per cycle, req/ack handshake.
module top_level
  import top_level_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req,
  output logic ack
);

  state_t      state_reg, state_next;
  job_t        job_reg, job_next;
  logic [4:0]  idx_reg, idx_next;
  logic [7:0]  hi_reg, hi_next;
  logic [7:0]  lo_reg, lo_next;
  logic [4:0]  pat_reg, pat_next;
  logic [7:0]  prev_reg, prev_next;
  logic [7:0]  cnt_match_reg, cnt_match_next;
  logic [7:0]  cnt_bytes_reg, cnt_bytes_next;
  logic [7:0]  cnt_win_reg, cnt_win_next;
  logic        ack_reg, ack_next;

  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  word_off;
  logic [15:0] enc_cw;
  logic [10:0] dec_data;
  logic        last_word;
  logic        last_byte;
  logic [15:0] scan_window;
  logic [7:0]  scan_match;
  logic [7:0]  byte_hits;
  logic [7:0]  cross_hits;

  data_mem data_mem1 (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  assign ack       = ack_reg;
  assign word_off  = {2'b00, idx_reg, 1'b0};
  assign enc_cw    = ham_encode({hi_reg[2:0], lo_reg});
  assign dec_data  = ham_decode({hi_reg, lo_reg});
  assign last_word = (idx_reg == 5'(NWORDS - 1));
  assign last_byte = (idx_reg == 5'(NBYTES - 1));

  // Previous byte sits above the current one, so windows 0..3 lie inside the current
  // byte and windows 4..7 straddle the byte boundary.
  assign scan_window = {prev_reg, mem_rdata};

  for (genvar gi = 0; gi < 8; gi++) begin : g_win
    assign scan_match[gi] = (scan_window[gi +: 5] == pat_reg);
  end

  assign byte_hits  = 8'(scan_match[0]) + 8'(scan_match[1]) +
                      8'(scan_match[2]) + 8'(scan_match[3]);
  assign cross_hits = 8'(scan_match[4]) + 8'(scan_match[5]) +
                      8'(scan_match[6]) + 8'(scan_match[7]);

  // Memory address and write data for the current state
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state_reg)
      J1_RD_HI:  mem_addr = P1_IN + word_off + 8'd1;
      J1_RD_LO:  mem_addr = P1_IN + word_off;
      J1_WR_HI: begin
        mem_addr  = P1_OUT + word_off + 8'd1;
        mem_we    = 1'b1;
        mem_wdata = enc_cw[15:8];
      end
      J1_WR_LO: begin
        mem_addr  = P1_OUT + word_off;
        mem_we    = 1'b1;
        mem_wdata = enc_cw[7:0];
      end
      J2_RD_HI:  mem_addr = P2_IN + word_off + 8'd1;
      J2_RD_LO:  mem_addr = P2_IN + word_off;
      J2_WR_HI: begin
        mem_addr  = P2_OUT + word_off + 8'd1;
        mem_we    = 1'b1;
        mem_wdata = {5'b00000, dec_data[10:8]};
      end
      J2_WR_LO: begin
        mem_addr  = P2_OUT + word_off;
        mem_we    = 1'b1;
        mem_wdata = dec_data[7:0];
      end
      J3_LD_PAT: mem_addr = PAT;
      J3_SCAN:   mem_addr = STR + {3'b000, idx_reg};
      J3_WR192: begin
        mem_addr  = RES;
        mem_we    = 1'b1;
        mem_wdata = cnt_match_reg;
      end
      J3_WR193: begin
        mem_addr  = RES + 8'd1;
        mem_we    = 1'b1;
        mem_wdata = cnt_bytes_reg;
      end
      J3_WR194: begin
        mem_addr  = RES + 8'd2;
        mem_we    = 1'b1;
        mem_wdata = cnt_win_reg;
      end
      default: ;
    endcase
  end

  // Next-state and datapath updates
  always_comb begin
    state_next     = state_reg;
    job_next       = job_reg;
    idx_next       = idx_reg;
    hi_next        = hi_reg;
    lo_next        = lo_reg;
    pat_next       = pat_reg;
    prev_next      = prev_reg;
    cnt_match_next = cnt_match_reg;
    cnt_bytes_next = cnt_bytes_reg;
    cnt_win_next   = cnt_win_reg;
    ack_next       = ack_reg;
    case (state_reg)
      IDLE: begin
        if (req) begin
          ack_next       = 1'b0;
          idx_next       = '0;
          prev_next      = '0;
          cnt_match_next = '0;
          cnt_bytes_next = '0;
          cnt_win_next   = '0;
          case (job_reg)
            JOB_ENC: state_next = J1_RD_HI;
            JOB_DEC: state_next = J2_RD_HI;
            default: state_next = J3_LD_PAT;
          endcase
        end
      end
      J1_RD_HI: begin
        hi_next    = mem_rdata;
        state_next = J1_RD_LO;
      end
      J1_RD_LO: begin
        lo_next    = mem_rdata;
        state_next = J1_WR_HI;
      end
      J1_WR_HI: state_next = J1_WR_LO;
      J1_WR_LO: begin
        if (last_word) begin
          idx_next   = '0;
          ack_next   = 1'b1;
          job_next   = next_job(job_reg);
          state_next = DONE;
        end else begin
          idx_next   = idx_reg + 5'd1;
          state_next = J1_RD_HI;
        end
      end
      J2_RD_HI: begin
        hi_next    = mem_rdata;
        state_next = J2_RD_LO;
      end
      J2_RD_LO: begin
        lo_next    = mem_rdata;
        state_next = J2_WR_HI;
      end
      J2_WR_HI: state_next = J2_WR_LO;
      J2_WR_LO: begin
        if (last_word) begin
          idx_next   = '0;
          ack_next   = 1'b1;
          job_next   = next_job(job_reg);
          state_next = DONE;
        end else begin
          idx_next   = idx_reg + 5'd1;
          state_next = J2_RD_HI;
        end
      end
      J3_LD_PAT: begin
        pat_next   = mem_rdata[4:0];
        state_next = J3_SCAN;
      end
      J3_SCAN: begin
        cnt_match_next = cnt_match_reg + byte_hits;
        if (byte_hits != 8'd0) begin
          cnt_bytes_next = cnt_bytes_reg + 8'd1;
        end
        // The first byte has no predecessor, so it contributes no straddling windows
        cnt_win_next = cnt_win_reg + byte_hits + ((idx_reg != 5'd0) ? cross_hits : 8'd0);
        prev_next    = mem_rdata;
        if (last_byte) begin
          idx_next   = '0;
          state_next = J3_WR192;
        end else begin
          idx_next   = idx_reg + 5'd1;
        end
      end
      J3_WR192: state_next = J3_WR193;
      J3_WR193: state_next = J3_WR194;
      J3_WR194: begin
        ack_next   = 1'b1;
        job_next   = next_job(job_reg);
        state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; memory contents survive reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      job_reg       <= JOB_ENC;
      idx_reg       <= '0;
      hi_reg        <= '0;
      lo_reg        <= '0;
      pat_reg       <= '0;
      prev_reg      <= '0;
      cnt_match_reg <= '0;
      cnt_bytes_reg <= '0;
      cnt_win_reg   <= '0;
      ack_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      job_reg       <= job_next;
      idx_reg       <= idx_next;
      hi_reg        <= hi_next;
      lo_reg        <= lo_next;
      pat_reg       <= pat_next;
      prev_reg      <= prev_next;
      cnt_match_reg <= cnt_match_next;
      cnt_bytes_reg <= cnt_bytes_next;
      cnt_win_reg   <= cnt_win_next;
      ack_reg       <= ack_next;
    end
  end

endmodule

// File: tb/tb_top_level.sv
// Self-checking bench for top_level: table-driven job vectors, random data checked
// against a behavioural model, plus handshake / reset-abort sequences.
module tb_top_level;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic req   = 1'b0;
  logic ack;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  in_hi;
    logic [7:0]  in_lo;
    logic [15:0] exp;
  } enc_vec_t;

  typedef struct {
    logic [15:0] cw;
    logic [15:0] exp;
  } dec_vec_t;

  typedef struct {
    logic [7:0] pat_byte;
    logic [7:0] fill;
    bit         rand_str;
    logic [7:0] e192;
    logic [7:0] e193;
    logic [7:0] e194;
  } pat_vec_t;

  enc_vec_t   enc_tab [15];
  dec_vec_t   dec_tab [15];
  pat_vec_t   pat_tab [5];
  logic [7:0] str_bytes [32];

  top_level dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .ack   (ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic mem_set(input logic [7:0] a, input logic [7:0] v);
    dut.data_mem1.core[a] = v;
  endtask

  function automatic logic [7:0] mem_get(input logic [7:0] a);
    return dut.data_mem1.core[a];
  endfunction

  // Reference encoder: place data, then each parity bit makes its coverage mask even
  function automatic logic [15:0] m_encode(input logic [10:0] d);
    logic [15:0] cw;
    cw       = '0;
    cw[3]    = d[0];
    cw[7:5]  = d[3:1];
    cw[15:9] = d[10:4];
    cw[1]    = ^(cw & 16'hAAAA);
    cw[2]    = ^(cw & 16'hCCCC);
    cw[4]    = ^(cw & 16'hF0F0);
    cw[8]    = ^(cw & 16'hFF00);
    cw[0]    = ^cw[15:1];
    return cw;
  endfunction

  // Reference pattern counter over the 256-bit string held in str_bytes
  task automatic m_patterns(input logic [7:0] pat_byte, output logic [7:0] c192,
                            output logic [7:0] c193, output logic [7:0] c194);
    logic [255:0] s;
    logic [7:0]   b;
    logic [4:0]   p;
    int           a, n, c, hits;
    p = pat_byte[4:0];
    a = 0; n = 0; c = 0;
    for (int k = 0; k < 32; k++) s[255 - 8*k -: 8] = str_bytes[k];
    for (int j = 0; j < 252; j++) if (s[255 - j -: 5] == p) c++;
    for (int k = 0; k < 32; k++) begin
      b = str_bytes[k];
      hits = 0;
      for (int w = 0; w < 4; w++) if (b[w +: 5] == p) hits++;
      a += hits;
      if (hits > 0) n++;
    end
    c192 = 8'(a);
    c193 = 8'(n);
    c194 = 8'(c);
  endtask

  task automatic load_enc(input int round);
    logic [7:0] h, l;
    for (int i = 0; i < 15; i++) begin
      h = 8'($urandom);
      l = 8'($urandom);
      enc_tab[i] = '{h, l, m_encode({h[2:0], l})};
    end
    if (round == 0) begin
      enc_tab[0] = '{8'h07, 8'hFF, 16'hFFFF};
      enc_tab[1] = '{8'h00, 8'h01, 16'h000F};
      enc_tab[2] = '{8'hF8, 8'h00, 16'h0000};
    end
    for (int i = 0; i < 15; i++) begin
      mem_set(8'(2*i + 1), enc_tab[i].in_hi);
      mem_set(8'(2*i), enc_tab[i].in_lo);
      mem_set(8'(31 + 2*i), 8'hA5);
      mem_set(8'(30 + 2*i), 8'hA5);
    end
  endtask

  task automatic check_enc(input string tag);
    for (int i = 0; i < 15; i++)
      check($sformatf("%s enc word%0d", tag, i),
            32'({mem_get(8'(31 + 2*i)), mem_get(8'(30 + 2*i))}), 32'(enc_tab[i].exp));
  endtask

  task automatic load_dec(input int round);
    logic [10:0] d;
    logic [15:0] cw;
    int          f;
    for (int i = 0; i < 15; i++) begin
      d  = 11'($urandom);
      f  = $urandom_range(0, 16);
      cw = m_encode(d);
      if (f < 16) cw = cw ^ (16'd1 << f);
      dec_tab[i] = '{cw, {5'b00000, d}};
    end
    if (round == 0) begin
      dec_tab[0] = '{m_encode(11'h5A3) ^ 16'h0200, 16'h05A3};
      dec_tab[1] = '{m_encode(11'h5A3) ^ 16'h0001, 16'h05A3};
      dec_tab[2] = '{m_encode(11'h000), 16'h0000};
      dec_tab[3] = '{m_encode(11'h7FF) ^ 16'h8000, 16'h07FF};
    end
    for (int i = 0; i < 15; i++) begin
      mem_set(8'(65 + 2*i), dec_tab[i].cw[15:8]);
      mem_set(8'(64 + 2*i), dec_tab[i].cw[7:0]);
      mem_set(8'(95 + 2*i), 8'hA5);
      mem_set(8'(94 + 2*i), 8'hA5);
    end
  endtask

  task automatic check_dec(input string tag);
    for (int i = 0; i < 15; i++)
      check($sformatf("%s dec word%0d", tag, i),
            32'({mem_get(8'(95 + 2*i)), mem_get(8'(94 + 2*i))}), 32'(dec_tab[i].exp));
  endtask

  task automatic load_pat(input int round);
    logic [7:0] e0, e1, e2;
    for (int k = 0; k < 32; k++) begin
      if (pat_tab[round].rand_str) begin
        case ($urandom_range(0, 3))
          0:       str_bytes[k] = 8'h00;
          1:       str_bytes[k] = 8'hFF;
          2:       str_bytes[k] = 8'h5A;
          default: str_bytes[k] = 8'($urandom);
        endcase
      end else begin
        str_bytes[k] = pat_tab[round].fill;
      end
      mem_set(8'(128 + k), str_bytes[k]);
    end
    if (pat_tab[round].rand_str) begin
      pat_tab[round].pat_byte = 8'($urandom);
      m_patterns(pat_tab[round].pat_byte, e0, e1, e2);
      pat_tab[round].e192 = e0;
      pat_tab[round].e193 = e1;
      pat_tab[round].e194 = e2;
    end
    mem_set(8'd160, pat_tab[round].pat_byte);
    mem_set(8'd192, 8'hA5);
    mem_set(8'd193, 8'hA5);
    mem_set(8'd194, 8'hA5);
  endtask

  task automatic check_pat(input string tag, input int round);
    check({tag, " core192"}, 32'(mem_get(8'd192)), 32'(pat_tab[round].e192));
    check({tag, " core193"}, 32'(mem_get(8'd193)), 32'(pat_tab[round].e193));
    check({tag, " core194"}, 32'(mem_get(8'd194)), 32'(pat_tab[round].e194));
  endtask

  // Bounded wait for ack, then one more cycle so the engine is back in IDLE
  task automatic wait_ack(input string tag);
    int n;
    n = 0;
    while (ack !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, " ack rise"}, 32'(ack), 32'd1);
    @(negedge clk);
  endtask

  task automatic run_job(input string tag);
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check({tag, " ack drop"}, 32'(ack), 32'd0);
    wait_ack(tag);
  endtask

  initial begin
    pat_tab[0] = '{8'h00, 8'h00, 1'b0, 8'd128, 8'd32, 8'd252};
    pat_tab[1] = '{8'h15, 8'h55, 1'b0, 8'd64,  8'd32, 8'd126};
    pat_tab[2] = '{8'hFF, 8'hFF, 1'b0, 8'd128, 8'd32, 8'd252};
    pat_tab[3] = '{8'h00, 8'h00, 1'b1, 8'd0,   8'd0,  8'd0};
    pat_tab[4] = '{8'h00, 8'h00, 1'b1, 8'd0,   8'd0,  8'd0};

    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset ack", 32'(ack), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle ack", 32'(ack), 32'd0);

    // Five full round-robin cycles: jobs 1, 2, 3 in order
    for (int r = 0; r < 5; r++) begin
      load_enc(r);
      run_job($sformatf("r%0d job1", r));
      check_enc($sformatf("r%0d", r));
      load_dec(r);
      run_job($sformatf("r%0d job2", r));
      check_dec($sformatf("r%0d", r));
      load_pat(r);
      run_job($sformatf("r%0d job3", r));
      check_pat($sformatf("r%0d job3", r), r);
    end

    // req held high across a busy job is accepted only once
    load_enc(1);
    @(negedge clk);
    req = 1'b1;
    repeat (20) @(negedge clk);
    check("held req busy ack", 32'(ack), 32'd0);
    req = 1'b0;
    wait_ack("held req");
    check_enc("held req");
    repeat (10) @(negedge clk);
    check("ack stays high", 32'(ack), 32'd1);

    // Pointer advanced exactly once: the next job must be the decoder
    load_dec(1);
    run_job("after held job2");
    check_dec("after held");

    // Reset in the middle of job 3 aborts it and rewinds the pointer to job 1
    load_pat(0);
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort ack", 32'(ack), 32'd0);
    check("abort core192", 32'(mem_get(8'd192)), 32'hA5);
    reset = 1'b1;
    @(negedge clk);
    load_enc(2);
    run_job("post-abort job1");
    check_enc("post-abort");
    check("post-abort core194", 32'(mem_get(8'd194)), 32'hA5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
